// File: rtl/relu_result_collector.sv
// relu_result_collector
// Captures per-unit ReLU results on each done pulse, packs the active lanes
// one per cycle into a feature-map buffer, and once a frame of frame_len
// results is stored, streams the buffer out to the host.
//
// Stream handshake: a beat transfers on a rising clk edge where m_valid and
// m_ready are both high. Once m_valid is raised, m_data and m_last hold
// until that transfer; m_valid never depends combinationally on m_ready.
module relu_result_collector #(
   parameter int DATA_WIDTH   = 16,
   parameter int NUM_UNITS    = 2,
   parameter int IMAGE_WIDTH  = 5,
   parameter int IMAGE_HEIGHT = 5,
   parameter int OUT_DEPTH    = IMAGE_WIDTH * IMAGE_HEIGHT,
   parameter int CW           = $clog2(OUT_DEPTH + 1)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            clear,
   input  logic [CW-1:0]                   frame_len,
   input  logic                            done,
   input  logic [NUM_UNITS-1:0]            active_units,
   input  logic [NUM_UNITS*DATA_WIDTH-1:0] relu_out,
   output logic                            m_valid,
   output logic [DATA_WIDTH-1:0]           m_data,
   output logic                            m_last,
   input  logic                            m_ready,
   output logic                            busy,
   output logic [CW-1:0]                   count,
   output logic                            err_overflow,
   output logic [1:0]                      dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PACK  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [CW-1:0] DEPTH_C = CW'(OUT_DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   state_t                            state_q, state_d;
   logic [NUM_UNITS-1:0]              stage_mask_q, stage_mask_d;
   logic [NUM_UNITS*DATA_WIDTH-1:0]   stage_data_q, stage_data_d;
   logic [CW-1:0]                     flen_q, flen_d;
   logic [CW-1:0]                     wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]                     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]                     count_q, count_d;
   logic                              err_q, err_d;
   logic                              m_valid_q, m_valid_d;
   logic [DATA_WIDTH-1:0]             m_data_q, m_data_d;
   logic                              m_last_q, m_last_d;

   logic [DATA_WIDTH-1:0]             fm_mem [OUT_DEPTH];
   logic                              mem_we;
   logic [CW-1:0]                     mem_waddr;
   logic [DATA_WIDTH-1:0]             mem_wdata;

   logic [DATA_WIDTH-1:0]             lane_data;
   logic [NUM_UNITS-1:0]              lane_sel;
   logic [NUM_UNITS-1:0]              mask_rest;
   logic [CW-1:0]                     flen_eff;
   logic [CW-1:0]                     rd_next;

   // Pick the lowest staged lane still pending; its data is the next write.
   always_comb begin
      lane_data = '0;
      lane_sel  = '0;
      for (int i = NUM_UNITS - 1; i >= 0; i--) begin
         if (stage_mask_q[i]) begin
            lane_data   = stage_data_q[i*DATA_WIDTH +: DATA_WIDTH];
            lane_sel    = '0;
            lane_sel[i] = 1'b1;
         end
      end
      mask_rest = stage_mask_q & ~lane_sel;
      // Zero or oversize frame lengths both mean "fill the whole buffer".
      flen_eff  = ((frame_len == '0) || (frame_len > DEPTH_C)) ? DEPTH_C : frame_len;
      rd_next   = rd_ptr_q + ONE_C;
   end

   // Next-state logic for the capture / pack / drain sequence.
   always_comb begin
      state_d      = state_q;
      stage_mask_d = stage_mask_q;
      stage_data_d = stage_data_q;
      flen_d       = flen_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      err_d        = err_q;
      m_valid_d    = m_valid_q;
      m_data_d     = m_data_q;
      m_last_d     = m_last_q;
      mem_we       = 1'b0;
      mem_waddr    = wr_ptr_q;
      mem_wdata    = lane_data;

      if (clear) begin
         // Abort wins over done and over any beat currently offered.
         state_d      = ST_IDLE;
         stage_mask_d = '0;
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         count_d      = '0;
         err_d        = 1'b0;
         m_valid_d    = 1'b0;
         m_data_d     = '0;
         m_last_d     = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (done && (active_units != '0)) begin
                  stage_mask_d = active_units;
                  stage_data_d = relu_out;
                  // Frame length is fixed by the first done of a frame.
                  if (count_q == '0) flen_d = flen_eff;
                  state_d = ST_PACK;
               end
            end
            ST_PACK: begin
               if (done) err_d = 1'b1;
               if (count_q < DEPTH_C) begin
                  mem_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + ONE_C;
                  count_d  = count_q + ONE_C;
               end else begin
                  // Buffer full: the lane is consumed but its result is lost.
                  err_d = 1'b1;
               end
               stage_mask_d = mask_rest;
               if (mask_rest == '0) begin
                  state_d = (count_d >= flen_q) ? ST_DRAIN : ST_IDLE;
               end
            end
            ST_DRAIN: begin
               if (done) err_d = 1'b1;
               if (!m_valid_q) begin
                  // First cycle in DRAIN: load the first word.
                  m_valid_d = 1'b1;
                  m_data_d  = fm_mem[rd_ptr_q];
                  m_last_d  = (rd_ptr_q == count_q - ONE_C);
               end else if (m_ready) begin
                  if (m_last_q) begin
                     wr_ptr_d  = '0;
                     rd_ptr_d  = '0;
                     count_d   = '0;
                     m_valid_d = 1'b0;
                     m_data_d  = '0;
                     m_last_d  = 1'b0;
                     state_d   = ST_IDLE;
                  end else begin
                     rd_ptr_d = rd_next;
                     m_data_d = fm_mem[rd_next];
                     m_last_d = (rd_next == count_q - ONE_C);
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State and control registers; async active-low reset clears everything.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         stage_mask_q <= '0;
         stage_data_q <= '0;
         flen_q       <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         err_q        <= 1'b0;
         m_valid_q    <= 1'b0;
         m_data_q     <= '0;
         m_last_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         stage_mask_q <= stage_mask_d;
         stage_data_q <= stage_data_d;
         flen_q       <= flen_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         err_q        <= err_d;
         m_valid_q    <= m_valid_d;
         m_data_q     <= m_data_d;
         m_last_q     <= m_last_d;
      end
   end

   // Feature-map buffer storage; contents need no reset.
   always_ff @(posedge clk) begin
      if (mem_we) fm_mem[mem_waddr] <= mem_wdata;
   end

   assign m_valid      = m_valid_q;
   assign m_data       = m_data_q;
   assign m_last       = m_last_q;
   assign busy         = (state_q != ST_IDLE);
   assign count        = count_q;
   assign err_overflow = err_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_relu_result_collector.sv
// Bench for relu_result_collector: directed scenarios plus randomized frames,
// every beat compared against a queue-based frame model.
module tb_relu_result_collector;

   localparam int DW    = 16;
   localparam int NU    = 2;
   localparam int DEPTH = 25;
   localparam int CW    = 5;

   logic              clk;
   logic              reset;
   logic              clear;
   logic [CW-1:0]     frame_len;
   logic              done;
   logic [NU-1:0]     active_units;
   logic [NU*DW-1:0]  relu_out;
   logic              m_valid;
   logic [DW-1:0]     m_data;
   logic              m_last;
   logic              m_ready;
   logic              busy;
   logic [CW-1:0]     count;
   logic              err_overflow;
   logic [1:0]        dbg_state;

   relu_result_collector #(
      .DATA_WIDTH(DW), .NUM_UNITS(NU), .IMAGE_WIDTH(5), .IMAGE_HEIGHT(5)
   ) dut (
      .clk(clk), .reset(reset), .clear(clear), .frame_len(frame_len),
      .done(done), .active_units(active_units), .relu_out(relu_out),
      .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
      .busy(busy), .count(count), .err_overflow(err_overflow),
      .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int            tests_run    = 0;
   int            tests_failed = 0;
   int            beat_cnt     = 0;
   logic [DW:0]   exp_q[$];          // {last, data} per expected beat
   logic [DW-1:0] mdl_frame[$];      // results of the frame being collected
   int            mdl_len = DEPTH;
   logic          mdl_err = 1'b0;
   int            ready_mode = 0;    // 0: always ready, 1: 1,0,0,1 pattern, 2: random

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: a done appends its active lanes in lane order; results
   // beyond the buffer depth are lost and flag an error; a frame is emitted
   // whole once it holds at least the effective frame length.
   task automatic model_done(input logic [NU-1:0] mask, input logic [NU*DW-1:0] data);
      int n;
      if (mask == '0) return;
      if (mdl_frame.size() == 0)
         mdl_len = (frame_len == 0 || int'(frame_len) > DEPTH) ? DEPTH : int'(frame_len);
      for (int i = 0; i < NU; i++) begin
         if (mask[i]) begin
            if (mdl_frame.size() < DEPTH) mdl_frame.push_back(data[i*DW +: DW]);
            else mdl_err = 1'b1;
         end
      end
      n = mdl_frame.size();
      if (n >= mdl_len) begin
         for (int k = 0; k < n; k++) exp_q.push_back({(k == n - 1), mdl_frame[k]});
         mdl_frame.delete();
      end
   endtask

   task automatic model_flush();
      exp_q.delete();
      mdl_frame.delete();
      mdl_err = 1'b0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_done(input logic [NU-1:0] mask, input logic [NU*DW-1:0] data);
      @(negedge clk);
      done = 1'b1; active_units = mask; relu_out = data;
      model_done(mask, data);
      @(negedge clk);
      done = 1'b0;
   endtask

   task automatic pulse_clear();
      @(negedge clk); clear = 1'b1;
      @(negedge clk); clear = 1'b0;
      model_flush();
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 300) begin @(negedge clk); n++; end
      check("idle_busy", busy, 0);
      check("idle_count", count, mdl_frame.size());
   endtask

   task automatic wait_drained();
      int n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || busy) && n < 600) begin @(negedge clk); n++; end
      check("drain_left", exp_q.size(), 0);
      check("drain_busy", busy, 0);
      check("drain_count", count, 0);
   endtask

   function automatic logic [NU*DW-1:0] rnd_data();
      logic [NU*DW-1:0] d;
      for (int i = 0; i < NU; i++) d[i*DW +: DW] = DW'($urandom);
      return d;
   endfunction

   // m_ready driver, changes just after each rising edge.
   initial begin
      logic [3:0] rpat;
      int rcyc;
      rpat = 4'b1001;
      rcyc = 0;
      m_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = rpat[rcyc % 4];
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
         rcyc++;
      end
   end

   // Stream monitor: ordering, last flag, and hold-during-stall.
   logic          prev_vld, prev_rdy, prev_clr, prev_last;
   logic [DW-1:0] prev_data;
   logic [DW:0]   exp_beat;
   initial prev_vld = 1'b0;
   always @(negedge clk) begin
      if (!reset) begin
         prev_vld = 1'b0;
      end else begin
         if (prev_vld && !prev_rdy && !prev_clr) begin
            check("stall_valid", m_valid, 1);
            check("stall_data", m_data, prev_data);
            check("stall_last", m_last, prev_last);
         end
         if (m_valid && m_ready && !clear) begin
            if (exp_q.size() == 0) begin
               check("beat_unexpected", exp_q.size(), 1);
            end else begin
               exp_beat = exp_q.pop_front();
               check("beat", {m_last, m_data}, exp_beat);
            end
            beat_cnt++;
         end
         prev_vld  = m_valid;
         prev_rdy  = m_ready;
         prev_clr  = clear;
         prev_data = m_data;
         prev_last = m_last;
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int b0;
      int n;
      logic [DW-1:0] a, b;
      reset = 1'b0; clear = 1'b0; frame_len = '0; done = 1'b0;
      active_units = '0; relu_out = '0;
      repeat (3) @(negedge clk);
      check("rst_valid", m_valid, 0);
      check("rst_data", m_data, 0);
      check("rst_last", m_last, 0);
      check("rst_busy", busy, 0);
      check("rst_count", count, 0);
      check("rst_err", err_overflow, 0);
      reset = 1'b1;
      ready_mode = 0;

      // Two full dones form a 4-result frame streamed in lane order.
      frame_len = 5'd4;
      do_done(2'b11, rnd_data());
      wait_idle();
      do_done(2'b11, rnd_data());
      wait_drained();

      // Single upper lane, frame of one; PACK takes exactly one cycle.
      frame_len = 5'd1;
      do_done(2'b10, {16'h0007, 16'h0003});
      @(negedge clk);
      check("t2_count", count, 1);
      check("t2_busy", busy, 1);
      check("t2_valid_early", m_valid, 0);
      @(negedge clk);
      check("t2_valid", m_valid, 1);
      check("t2_data", m_data, 16'h0007);
      check("t2_last", m_last, 1);
      wait_drained();

      // Stalled stream with the 1,0,0,1 ready pattern.
      ready_mode = 1;
      frame_len = 5'd4;
      do_done(2'b11, rnd_data());
      wait_idle();
      do_done(2'b11, rnd_data());
      wait_drained();
      ready_mode = 0;

      // done while packing is dropped and flags overflow until clear.
      frame_len = 5'd4;
      @(negedge clk);
      done = 1'b1; active_units = 2'b11; relu_out = rnd_data();
      model_done(active_units, relu_out);
      @(negedge clk);
      relu_out = rnd_data();
      mdl_err = 1'b1;
      @(negedge clk);
      done = 1'b0;
      wait_idle();
      check("t4_err", err_overflow, mdl_err);
      repeat (3) @(negedge clk);
      check("t4_err_sticky", err_overflow, 1);
      pulse_clear();
      check("t4_clr_err", err_overflow, mdl_err);
      check("t4_clr_count", count, 0);

      // frame_len 0 means the full buffer; the 26th result overflows.
      frame_len = 5'd0;
      for (int k = 0; k < 12; k++) begin
         do_done(2'b11, rnd_data());
         wait_idle();
      end
      do_done(2'b11, rnd_data());
      n = 0;
      while (!m_valid && n < 20) begin @(negedge clk); n++; end
      check("t5_valid", m_valid, 1);
      check("t5_count", count, DEPTH);
      check("t5_err", err_overflow, mdl_err);
      wait_drained();
      check("t5_err_after", err_overflow, 1);
      pulse_clear();

      // Reset in the middle of a drain, then a fresh two-result frame.
      frame_len = 5'd4;
      do_done(2'b11, rnd_data());
      wait_idle();
      b0 = beat_cnt;
      do_done(2'b11, rnd_data());
      n = 0;
      while (beat_cnt < b0 + 2 && n < 50) begin @(posedge clk); n++; end
      check("t6_beats_before", beat_cnt - b0, 2);
      #1 reset = 1'b0;
      #1;
      check("t6_valid", m_valid, 0);
      check("t6_data", m_data, 0);
      check("t6_last", m_last, 0);
      check("t6_busy", busy, 0);
      check("t6_count", count, 0);
      model_flush();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      frame_len = 5'd2;
      a = DW'($urandom); b = DW'($urandom);
      do_done(2'b11, {b, a});
      n = 0;
      while (!m_valid && n < 20) begin @(negedge clk); n++; end
      check("t6_first_data", m_data, a);
      wait_drained();

      // Randomized frames with random back-pressure.
      ready_mode = 2;
      for (int k = 0; k < 40; k++) begin
         frame_len = CW'($urandom_range(1, 6));
         do_done(NU'($urandom_range(0, 3)), rnd_data());
         wait_idle();
      end
      // Flush any partial frame by completing it with single-lane dones.
      n = 0;
      while (mdl_frame.size() != 0 && n < 10) begin
         do_done(2'b01, rnd_data());
         wait_idle();
         n++;
      end
      wait_drained();
      check("rand_err", err_overflow, mdl_err);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
